cpu_unit: RTL and testbench

CPU_UNIT -- requirements
Module: cpu_unit

---
 rtl/cpu_unit_pkg.sv | 44 ++++
 rtl/cpu_unit_cache_array.sv | 56 +++++
 rtl/cpu_unit.sv | 195 +++++++++++++++++++
 tb/tb_cpu_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_unit_pkg.sv
// Shared types for the CPU cache unit: bus address, MESI state, FSM states.
package definesPkg;

  localparam int NUM_LINES = 4;
  localparam int IDX_W     = 2;
  localparam int TAG_W     = 10;

  typedef struct packed {
    logic [3:0] Page_reference;
    logic [7:0] Address_code;
  } Taddress;

  typedef enum logic [1:0] {
    INV = 2'd0,
    SHR = 2'd1,
    EXC = 2'd2,
    MOD = 2'd3
  } Tmesi_state;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    WB_REQ  = 3'd2,
    WB      = 3'd3,
    RD_REQ  = 3'd4,
    RD_WAIT = 3'd5,
    FILL    = 3'd6
  } Tcpu_state;

  // Tag is everything above the 2-bit line index.
  function automatic logic [TAG_W-1:0] addr_tag(input Taddress a);
    return {a.Page_reference, a.Address_code[7:2]};
  endfunction

  // Rebuild the full bus address of a resident line from its tag and index.
  function automatic Taddress tag_to_addr(input logic [TAG_W-1:0] tag,
                                          input logic [IDX_W-1:0] idx);
    Taddress a;
    a.Page_reference = tag[TAG_W-1 -: 4];
    a.Address_code   = {tag[5:0], idx};
    return a;
  endfunction

endpackage

// File: rtl/cpu_unit_cache_array.sv
// Four-line direct-mapped storage: data, tag and MESI state per line.
module cpu_cache_array
  import definesPkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_index,
  output logic [63:0]      rd_data,
  output logic [TAG_W-1:0] rd_tag,
  output Tmesi_state       rd_mesi,
  input  logic             we,
  input  logic [IDX_W-1:0] w_index,
  input  logic [63:0]      wdata,
  input  logic [TAG_W-1:0] w_tag,
  input  Tmesi_state       w_mesi
);

  logic [63:0]      data_q [NUM_LINES];
  logic [63:0]      data_d [NUM_LINES];
  logic [TAG_W-1:0] tag_q  [NUM_LINES];
  logic [TAG_W-1:0] tag_d  [NUM_LINES];
  Tmesi_state       mesi_q [NUM_LINES];
  Tmesi_state       mesi_d [NUM_LINES];

  assign rd_data = data_q[rd_index];
  assign rd_tag  = tag_q[rd_index];
  assign rd_mesi = mesi_q[rd_index];

  // Single write port updates one whole line (data, tag, state) at a time.
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    mesi_d = mesi_q;
    if (we) begin
      data_d[w_index] = wdata;
      tag_d[w_index]  = w_tag;
      mesi_d[w_index] = w_mesi;
    end
  end

  // Line storage; reset invalidates and clears every line.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
        mesi_q[i] <= INV;
      end
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
      mesi_q <= mesi_d;
    end
  end

endmodule

// File: rtl/cpu_unit.sv
// CPU-side cache controller: lookup, dirty-victim write-back, line fill.
//
// state   | meaning
// IDLE    | waiting for read_start / write_start
// LOOKUP  | compare latched address against its line
// WB_REQ  | requesting bus to write back a modified victim
// WB      | one-cycle write-back strobe; victim invalidated
// RD_REQ  | requesting bus to fetch the wanted line
// RD_WAIT | bus owned, waiting for read_mm_completed
// FILL    | line filled; finish read or merge write data
module cpu_unit
  import definesPkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        gnt_CPU,
  input  logic [63:0] data_from_memory,
  input  Tmesi_state  rd_mesi_state,
  input  logic        read_mm_completed,
  output logic        req_CPU,
  output Taddress     addr_wanted_from_memory,
  output logic [63:0] wdata_to_memory,
  output logic        we_to_mm
);

  // Operation request, driven from outside the module.
  logic        read_start;
  logic        write_start;
  Taddress     address_to_read;
  logic [63:0] cpu_wdata;

  // Cache write port and operation result.
  logic [63:0] wdata;
  logic        we;
  logic [63:0] read_data;
  logic        op_done;

  Tcpu_state        state_q, state_d;
  logic             op_write_q, op_write_d;
  Taddress          addr_q, addr_d;
  logic [63:0]      cpu_wdata_q, cpu_wdata_d;
  logic [63:0]      read_data_q, read_data_d;
  logic             op_done_q, op_done_d;
  logic             req_q, req_d;
  Taddress          bus_addr_q, bus_addr_d;
  logic [63:0]      wb_data_q, wb_data_d;
  logic             we_mm_q, we_mm_d;

  logic [IDX_W-1:0] line_idx;
  logic [63:0]      line_data;
  logic [TAG_W-1:0] line_tag, w_tag;
  Tmesi_state       line_mesi, w_mesi;
  logic             hit;

  assign line_idx = addr_q.Address_code[IDX_W-1:0];
  assign hit      = (line_tag == addr_tag(addr_q)) && (line_mesi != INV);

  cpu_cache_array u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_index (line_idx),
    .rd_data  (line_data),
    .rd_tag   (line_tag),
    .rd_mesi  (line_mesi),
    .we       (we),
    .w_index  (line_idx),
    .wdata    (wdata),
    .w_tag    (w_tag),
    .w_mesi   (w_mesi)
  );

  assign req_CPU                 = req_q;
  assign addr_wanted_from_memory = bus_addr_q;
  assign wdata_to_memory         = wb_data_q;
  assign we_to_mm                = we_mm_q;
  assign read_data               = read_data_q;
  assign op_done                 = op_done_q;

  // Next-state, next-output and cache write-port decode.
  always_comb begin
    state_d     = state_q;
    op_write_d  = op_write_q;
    addr_d      = addr_q;
    cpu_wdata_d = cpu_wdata_q;
    read_data_d = read_data_q;
    op_done_d   = 1'b0;
    req_d       = req_q;
    bus_addr_d  = bus_addr_q;
    wb_data_d   = '0;
    we_mm_d     = 1'b0;
    we          = 1'b0;
    wdata       = line_data;
    w_tag       = line_tag;
    w_mesi      = line_mesi;
    case (state_q)
      IDLE: begin
        if (read_start || write_start) begin
          op_write_d  = write_start && !read_start;
          addr_d      = address_to_read;
          cpu_wdata_d = cpu_wdata;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          if (op_write_q) begin
            we     = 1'b1;
            wdata  = cpu_wdata_q;
            w_mesi = MOD;
          end else begin
            read_data_d = line_data;
          end
          op_done_d = 1'b1;
          state_d   = IDLE;
        end else if (line_mesi == MOD) begin
          req_d      = 1'b1;
          bus_addr_d = tag_to_addr(line_tag, line_idx);
          state_d    = WB_REQ;
        end else begin
          req_d      = 1'b1;
          bus_addr_d = addr_q;
          state_d    = RD_REQ;
        end
      end
      WB_REQ: begin
        if (gnt_CPU) begin
          we_mm_d   = 1'b1;
          wb_data_d = line_data;
          state_d   = WB;
        end
      end
      WB: begin
        we         = 1'b1;
        w_mesi     = INV;
        bus_addr_d = addr_q;
        state_d    = RD_REQ;
      end
      RD_REQ: begin
        if (gnt_CPU) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (read_mm_completed) begin
          we         = 1'b1;
          wdata      = data_from_memory;
          w_tag      = addr_tag(addr_q);
          w_mesi     = rd_mesi_state;
          req_d      = 1'b0;
          bus_addr_d = '0;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (op_write_q) begin
          we     = 1'b1;
          wdata  = cpu_wdata_q;
          w_mesi = MOD;
        end else begin
          read_data_d = line_data;
        end
        op_done_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) we = 1'b0;
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_write_q  <= 1'b0;
      addr_q      <= '0;
      cpu_wdata_q <= '0;
      read_data_q <= '0;
      op_done_q   <= 1'b0;
      req_q       <= 1'b0;
      bus_addr_q  <= '0;
      wb_data_q   <= '0;
      we_mm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_write_q  <= op_write_d;
      addr_q      <= addr_d;
      cpu_wdata_q <= cpu_wdata_d;
      read_data_q <= read_data_d;
      op_done_q   <= op_done_d;
      req_q       <= req_d;
      bus_addr_q  <= bus_addr_d;
      wb_data_q   <= wb_data_d;
      we_mm_q     <= we_mm_d;
    end
  end

endmodule

// File: tb/tb_cpu_unit.sv
// Bench for cpu_unit: directed vector table, randomized ops against a
// line-level cache model, and a reset-during-fill sequence.
module tb_cpu_unit;
  import definesPkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        gnt_CPU;
  logic [63:0] data_from_memory;
  Tmesi_state  rd_mesi_state;
  logic        read_mm_completed;
  logic        req_CPU;
  Taddress     addr_wanted_from_memory;
  logic [63:0] wdata_to_memory;
  logic        we_to_mm;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cpu_unit dut (
    .clk                     (clk),
    .reset                   (reset),
    .gnt_CPU                 (gnt_CPU),
    .data_from_memory        (data_from_memory),
    .rd_mesi_state           (rd_mesi_state),
    .read_mm_completed       (read_mm_completed),
    .req_CPU                 (req_CPU),
    .addr_wanted_from_memory (addr_wanted_from_memory),
    .wdata_to_memory         (wdata_to_memory),
    .we_to_mm                (we_to_mm)
  );

  // Reference cache: per line data, tag (page*64 + code/4), MESI state.
  logic [63:0] m_data  [4];
  int          m_tag   [4];
  Tmesi_state  m_state [4];

  typedef struct {
    bit          wr;
    bit          both;
    logic [3:0]  page;
    logic [7:0]  code;
    logic [63:0] wd;
    logic [63:0] fd;
    Tmesi_state  fs;
    bit          hit;
    bit          wb;
    logic [63:0] rd;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_data[i]  = '0;
      m_tag[i]   = 0;
      m_state[i] = INV;
    end
  endtask

  task automatic check_lines(input string name);
    for (int i = 0; i < 4; i++) begin
      check({name, " state"}, 64'(dut.u_array.mesi_q[i]), 64'(m_state[i]));
      check({name, " tag"},   64'(dut.u_array.tag_q[i]),  64'(m_tag[i]));
      check({name, " data"},  dut.u_array.data_q[i],      m_data[i]);
    end
  endtask

  // One operation, acting as arbiter and memory; expectations passed in.
  task automatic run_op(input string nm, input bit wr, input bit both, input Taddress a,
                        input logic [63:0] wd, input logic [63:0] fd, input Tmesi_state fs,
                        input bit exp_hit, input bit exp_wb, input logic [63:0] exp_rd,
                        input bit spurious);
    int idx = int'(a.Address_code) % 4;
    int tg  = int'(a.Page_reference) * 64 + int'(a.Address_code) / 4;
    Taddress vaddr;
    logic [63:0] vdata, got_rd;
    int wb_cnt = 0, cyc = 0, first_req = -1, done_cyc = -1, rd_wait = 0;
    bit addr_ok = 1, wd_ok = 1, hold_ok = 1, rd_granted = 0, completed = 0, req_seen = 0;
    vaddr.Page_reference = 4'(m_tag[idx] / 64);
    vaddr.Address_code   = 8'((m_tag[idx] % 64) * 4 + idx);
    vdata  = m_data[idx];
    got_rd = '0;
    @(negedge clk);
    dut.read_start      = !wr || both;
    dut.write_start     = wr || both;
    dut.address_to_read = a;
    dut.cpu_wdata       = wd;
    @(negedge clk);
    dut.read_start  = 1'b0;
    dut.write_start = 1'b0;
    while (done_cyc < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      read_mm_completed = 1'b0;
      dut.read_start    = 1'b0;
      if (dut.op_done) begin
        done_cyc = cyc;
        got_rd   = dut.read_data;
      end
      if (req_CPU) begin
        req_seen = 1;
        if (first_req < 0) first_req = cyc;
        if (exp_wb && wb_cnt == 0) begin
          if (addr_wanted_from_memory !== vaddr) addr_ok = 0;
        end else if (addr_wanted_from_memory !== a) addr_ok = 0;
      end
      if (rd_granted && !completed && !req_CPU) hold_ok = 0;
      if (we_to_mm) begin
        wb_cnt++;
        if (wdata_to_memory !== vdata) wd_ok = 0;
      end
      if (done_cyc < 0) begin
        if (rd_granted && !completed) begin
          if (rd_wait == 0) begin
            read_mm_completed = 1'b1;
            data_from_memory  = fd;
            rd_mesi_state     = fs;
            completed         = 1;
          end else rd_wait--;
        end
        gnt_CPU = req_CPU && ($urandom_range(0, 2) != 0);
        if (gnt_CPU && !rd_granted && !we_to_mm && addr_wanted_from_memory == a) begin
          rd_granted = 1;
          rd_wait    = $urandom_range(0, 3);
        end
        if (spurious && cyc == 2) begin
          dut.read_start      = 1'b1;
          dut.address_to_read = Taddress'(12'($urandom));
        end
      end
    end
    gnt_CPU           = 1'b0;
    read_mm_completed = 1'b0;
    dut.read_start    = 1'b0;
    check({nm, " op_done seen"}, 64'(done_cyc > 0), 64'd1);
    if (exp_hit) begin
      check({nm, " hit latency"}, 64'(done_cyc), 64'd1);
      check({nm, " hit no req"}, 64'(req_seen), 64'd0);
    end else begin
      check({nm, " req next cycle"}, 64'(first_req), 64'd1);
      check({nm, " bus addr"}, 64'(addr_ok), 64'd1);
      check({nm, " req held"}, 64'(hold_ok), 64'd1);
    end
    check({nm, " wb count"}, 64'(wb_cnt), 64'(exp_wb));
    if (exp_wb) check({nm, " wb data"}, 64'(wd_ok), 64'd1);
    if (!wr || both) check({nm, " read_data"}, got_rd, exp_rd);
    if (!exp_hit) begin
      m_data[idx]  = fd;
      m_tag[idx]   = tg;
      m_state[idx] = fs;
    end
    if (wr && !both) begin
      m_data[idx]  = wd;
      m_state[idx] = MOD;
    end
    check({nm, " line state"}, 64'(dut.u_array.mesi_q[idx]), 64'(m_state[idx]));
    check({nm, " line data"}, dut.u_array.data_q[idx], m_data[idx]);
    @(negedge clk);
    @(negedge clk);
    check({nm, " idle quiet"},
          64'({req_CPU, addr_wanted_from_memory, wdata_to_memory != 64'd0, we_to_mm, dut.op_done}),
          64'd0);
  endtask

  // Expectations derived from the reference model.
  task automatic model_op(input string nm, input bit wr, input Taddress a,
                          input logic [63:0] wd, input logic [63:0] fd,
                          input Tmesi_state fs, input bit spurious);
    int idx = int'(a.Address_code) % 4;
    int tg  = int'(a.Page_reference) * 64 + int'(a.Address_code) / 4;
    bit h   = (m_tag[idx] == tg) && (m_state[idx] != INV);
    bit w   = !h && (m_state[idx] == MOD);
    run_op(nm, wr, 1'b0, a, wd, fd, fs, h, w, h ? m_data[idx] : fd, spurious);
  endtask

  initial begin
    Taddress a;
    Taddress tgt;
    bit reached;
    reset             = 1'b1;
    gnt_CPU           = 1'b0;
    data_from_memory  = '0;
    rd_mesi_state     = INV;
    read_mm_completed = 1'b0;
    dut.read_start      = 1'b0;
    dut.write_start     = 1'b0;
    dut.address_to_read = '0;
    dut.cpu_wdata       = '0;
    model_clear();

    tbl[0] = '{0, 0, 4'd0, 8'd1, 64'h0,    64'hDEADBEEFDEADBEEF, EXC, 0, 0, 64'hDEADBEEFDEADBEEF};
    tbl[1] = '{0, 0, 4'd0, 8'd1, 64'h0,    64'h0,                EXC, 1, 0, 64'hDEADBEEFDEADBEEF};
    tbl[2] = '{1, 0, 4'd0, 8'd1, 64'h1234, 64'h0,                EXC, 1, 0, 64'h0};
    tbl[3] = '{0, 0, 4'd1, 8'd1, 64'h0,    64'hCAFEF00D00000001, SHR, 0, 1, 64'hCAFEF00D00000001};
    tbl[4] = '{0, 0, 4'd2, 8'd2, 64'h0,    64'h5555AAAA5555AAAA, INV, 0, 0, 64'h5555AAAA5555AAAA};
    tbl[5] = '{0, 0, 4'd2, 8'd2, 64'h0,    64'h0123456789ABCDEF, EXC, 0, 0, 64'h0123456789ABCDEF};
    tbl[6] = '{1, 0, 4'd0, 8'd3, 64'hFEED, 64'h7777,             SHR, 0, 0, 64'h0};
    tbl[7] = '{1, 1, 4'd0, 8'd3, 64'hBAD,  64'h0,                SHR, 1, 0, 64'hFEED};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset req_CPU", 64'(req_CPU), 64'd0);
    check("reset bus outputs",
          64'({addr_wanted_from_memory, wdata_to_memory != 64'd0, we_to_mm}), 64'd0);
    check("reset op_done", 64'(dut.op_done), 64'd0);
    check("reset fsm idle", 64'(dut.state_q), 64'(IDLE));
    check_lines("reset");

    for (int i = 0; i < 8; i++) begin
      a.Page_reference = tbl[i].page;
      a.Address_code   = tbl[i].code;
      run_op($sformatf("vec%0d", i), tbl[i].wr, tbl[i].both, a, tbl[i].wd, tbl[i].fd,
             tbl[i].fs, tbl[i].hit, tbl[i].wb, tbl[i].rd, 1'b0);
    end
    check_lines("after vectors");

    for (int i = 0; i < 40; i++) begin
      a.Page_reference = 4'($urandom_range(0, 2));
      a.Address_code   = 8'($urandom_range(0, 7));
      model_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
               {$urandom, $urandom}, Tmesi_state'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
    end
    check_lines("after random");

    // Reset while waiting for fill data.
    tgt.Page_reference = 4'd3;
    tgt.Address_code   = 8'd4;
    @(negedge clk);
    dut.read_start      = 1'b1;
    dut.address_to_read = tgt;
    @(negedge clk);
    dut.read_start = 1'b0;
    reached = 0;
    for (int k = 0; k < 30 && !reached; k++) begin
      @(negedge clk);
      gnt_CPU = req_CPU;
      if (req_CPU && !we_to_mm && addr_wanted_from_memory == tgt) reached = 1;
    end
    check("reach rd_wait", 64'(reached), 64'd1);
    @(negedge clk);
    gnt_CPU = 1'b0;
    check("rd_wait req held", 64'(req_CPU), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    check("mid reset req_CPU", 64'(req_CPU), 64'd0);
    check("mid reset fsm idle", 64'(dut.state_q), 64'(IDLE));
    check("mid reset bus outputs",
          64'({addr_wanted_from_memory, wdata_to_memory != 64'd0, we_to_mm}), 64'd0);
    check_lines("mid reset");

    a.Page_reference = 4'd0;
    a.Address_code   = 8'd1;
    run_op("post reset", 1'b0, 1'b0, a, 64'h0, 64'hA5A5A5A5A5A5A5A5, SHR,
           1'b0, 1'b0, 64'hA5A5A5A5A5A5A5A5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
